// File: rtl/spcp_pkg.sv
// Shared types and constants for the zero-crossing trigger detector.
package spcp_pkg;

   typedef enum logic [2:0] {
      ST_UNARMED,
      ST_POS,
      ST_NEG,
      ST_PEND_NEG,
      ST_PEND_POS
   } spcp_state_e;

   // Bit positions inside the zero_spcp trigger bus.
   localparam int STROBE = 2;
   localparam int DIR    = 1;
   localparam int SIGN   = 0;

endpackage

// File: rtl/spcp_strobe_stretch.sv
// Stretches a one-cycle load into a STROBE_LEN-cycle strobe; a load while the
// strobe is already high inserts a single low cycle so the consumer sees a fresh rising edge.
module spcp_strobe_stretch #(
   parameter int STROBE_LEN = 8
) (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic clear_i,
   input  logic load_i,
   output logic strobe_o
);

   localparam int CW = $clog2(STROBE_LEN + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(STROBE_LEN);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] strobeCnt_q, strobeCnt_d;
   logic          gap_q, gap_d;

   always_comb begin
      strobeCnt_d = strobeCnt_q;
      gap_d       = 1'b0;
      if (clear_i) begin
         strobeCnt_d = '0;
      end else if (load_i && (strobeCnt_q != '0)) begin
         strobeCnt_d = '0;
         gap_d       = 1'b1;
      end else if (load_i || gap_q) begin
         strobeCnt_d = LOAD_VAL;
      end else if (strobeCnt_q != '0) begin
         strobeCnt_d = strobeCnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         strobeCnt_q <= '0;
         gap_q       <= 1'b0;
      end else begin
         strobeCnt_q <= strobeCnt_d;
         gap_q       <= gap_d;
      end
   end

   assign strobe_o = (strobeCnt_q != '0);

endmodule

// File: rtl/spcp_zero_cross.sv
// Hysteresis zero-crossing detector driving the zero_spcp trigger bus, plus a
// period counter measured between positive-going crossings.
module spcp_zero_cross
   import spcp_pkg::*;
#(
   parameter int S_AXIS_DATA_WIDTH = 16,
   parameter int STROBE_LEN        = 8,
   parameter int PERIOD_WIDTH      = 32
) (
   input  logic                         a_clk,
   input  logic                         a_resetn,
   input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                         S_AXIS_tvalid,
   input  logic                         enable,
   input  logic [15:0]                  hysteresis,
   input  logic [7:0]                   min_hold,
   output logic [2:0]                   zero_spcp,
   output logic [PERIOD_WIDTH-1:0]      period,
   output logic                         period_valid
);

   // One extra bit beyond the wider operand keeps x vs +/-h free of overflow.
   localparam int CW = (S_AXIS_DATA_WIDTH + 1 > 17) ? S_AXIS_DATA_WIDTH + 1 : 17;
   localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);

   logic signed [CW-1:0] sampleExt, hPos, hNeg;
   logic                 isHi, isLo;
   logic [7:0]           holdEff, holdNext;

   spcp_state_e state_q, state_d;
   logic [7:0]  holdCnt_q, holdCnt_d;
   logic        confirm_q, confirm_d;
   logic        confirmDir_q, confirmDir_d;

   logic                    dir_q, dir_d;
   logic                    sign_q, sign_d;
   logic                    seenPos_q, seenPos_d;
   logic [PERIOD_WIDTH-1:0] periodCnt_q, periodCnt_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    periodValid_q, periodValid_d;
   logic                    strobe;

   assign sampleExt = {{(CW-S_AXIS_DATA_WIDTH){S_AXIS_tdata[S_AXIS_DATA_WIDTH-1]}}, S_AXIS_tdata};
   assign hPos      = {{(CW-16){1'b0}}, hysteresis};
   assign hNeg      = -hPos;
   assign isHi      = (sampleExt > hPos);
   assign isLo      = (sampleExt < hNeg);
   assign holdEff   = (min_hold == 8'd0) ? 8'd1 : min_hold;
   assign holdNext  = holdCnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      holdCnt_d    = holdCnt_q;
      confirm_d    = 1'b0;
      confirmDir_d = confirmDir_q;
      if (!enable) begin
         state_d   = ST_UNARMED;
         holdCnt_d = '0;
      end else if (S_AXIS_tvalid) begin
         unique case (state_q)
            ST_UNARMED: begin
               if (isHi)      state_d = ST_POS;
               else if (isLo) state_d = ST_NEG;
            end
            ST_POS: begin
               if (isLo) begin
                  if (holdEff == 8'd1) begin
                     state_d      = ST_NEG;
                     confirm_d    = 1'b1;
                     confirmDir_d = 1'b0;
                  end else begin
                     state_d   = ST_PEND_NEG;
                     holdCnt_d = 8'd1;
                  end
               end
            end
            // min_hold may have been lowered mid-pend, hence >= rather than ==.
            ST_PEND_NEG: begin
               if (!isLo) begin
                  state_d   = ST_POS;
                  holdCnt_d = '0;
               end else if (holdNext >= holdEff) begin
                  state_d      = ST_NEG;
                  holdCnt_d    = '0;
                  confirm_d    = 1'b1;
                  confirmDir_d = 1'b0;
               end else begin
                  holdCnt_d = holdNext;
               end
            end
            ST_NEG: begin
               if (isHi) begin
                  if (holdEff == 8'd1) begin
                     state_d      = ST_POS;
                     confirm_d    = 1'b1;
                     confirmDir_d = 1'b1;
                  end else begin
                     state_d   = ST_PEND_POS;
                     holdCnt_d = 8'd1;
                  end
               end
            end
            ST_PEND_POS: begin
               if (!isHi) begin
                  state_d   = ST_NEG;
                  holdCnt_d = '0;
               end else if (holdNext >= holdEff) begin
                  state_d      = ST_POS;
                  holdCnt_d    = '0;
                  confirm_d    = 1'b1;
                  confirmDir_d = 1'b1;
               end else begin
                  holdCnt_d = holdNext;
               end
            end
            default: begin
               state_d   = ST_UNARMED;
               holdCnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge a_clk) begin
      if (!a_resetn) begin
         state_q      <= ST_UNARMED;
         holdCnt_q    <= '0;
         confirm_q    <= 1'b0;
         confirmDir_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         holdCnt_q    <= holdCnt_d;
         confirm_q    <= confirm_d;
         confirmDir_q <= confirmDir_d;
      end
   end

   // A confirm registered in the previous cycle is applied here, so a disable
   // arriving in the same cycle still suppresses it.
   always_comb begin
      dir_d         = dir_q;
      sign_d        = sign_q;
      seenPos_d     = seenPos_q;
      period_d      = period_q;
      periodValid_d = 1'b0;
      periodCnt_d   = (periodCnt_q == '1) ? periodCnt_q : periodCnt_q + PERIOD_ONE;
      if (!enable) begin
         seenPos_d   = 1'b0;
         periodCnt_d = '0;
      end else if (confirm_q) begin
         dir_d  = confirmDir_q;
         sign_d = confirmDir_q;
         if (confirmDir_q) begin
            if (seenPos_q) begin
               period_d      = periodCnt_q;
               periodValid_d = 1'b1;
            end
            seenPos_d   = 1'b1;
            periodCnt_d = PERIOD_ONE;
         end
      end
   end

   always_ff @(posedge a_clk) begin
      if (!a_resetn) begin
         dir_q         <= 1'b0;
         sign_q        <= 1'b0;
         seenPos_q     <= 1'b0;
         periodCnt_q   <= '0;
         period_q      <= '0;
         periodValid_q <= 1'b0;
      end else begin
         dir_q         <= dir_d;
         sign_q        <= sign_d;
         seenPos_q     <= seenPos_d;
         periodCnt_q   <= periodCnt_d;
         period_q      <= period_d;
         periodValid_q <= periodValid_d;
      end
   end

   spcp_strobe_stretch #(
      .STROBE_LEN(STROBE_LEN)
   ) u_stretch (
      .clk_i    (a_clk),
      .resetn_i (a_resetn),
      .clear_i  (!enable),
      .load_i   (confirm_q && enable),
      .strobe_o (strobe)
   );

   assign zero_spcp[STROBE] = strobe;
   assign zero_spcp[DIR]    = dir_q;
   assign zero_spcp[SIGN]   = sign_q;
   assign period            = period_q;
   assign period_valid      = periodValid_q;

endmodule
